// File: rtl/acc_buffer_pkg.sv
// Shared types and helpers for the accumulate output buffer: pass phase encoding
// and lane sign extension.
package acc_buffer_pkg;

  typedef enum logic [1:0] {PH_FIRST, PH_MIDDLE, PH_LAST} acc_phase_t;

  localparam int SEXT_W = 64;

  // Sign-extends the low from_w bits of value to SEXT_W bits; callers truncate to
  // their accumulator width.
  function automatic logic [SEXT_W-1:0] sext_lane(input logic [SEXT_W-1:0] value,
                                                  input int from_w);
    int sh;
    logic [SEXT_W-1:0] t;
    sh = SEXT_W - from_w;
    t  = value << sh;
    return $signed(t) >>> sh;
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered read that
// holds its value while rd_en is low.
module sdp_ram #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 512,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; stale contents are
  // never read because the first pass of a tile overwrites every address.
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/unpacked_register_slice.sv
// Single-entry valid/ready pipeline register for an unpacked array of lanes; output
// holds stable while valid and not ready.
module unpacked_register_slice #(
  parameter int DATA_WIDTH = 24,
  parameter int IN_SIZE    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in [IN_SIZE],
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  output logic [DATA_WIDTH-1:0] data_out [IN_SIZE],
  output logic                  data_out_valid,
  input  logic                  data_out_ready
);

  assign data_in_ready = !data_out_valid || data_out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_valid <= 1'b0;
      data_out       <= '{default: '0};
    end else if (data_in_ready) begin
      data_out_valid <= data_in_valid;
      if (data_in_valid) data_out <= data_in;
    end
  end

endmodule

// File: rtl/accumulate_output_buffer.sv
// Sums REPEAT passes of BUFFER_SIZE partial-result beats in per-lane RAM and emits
// only the final, fully accumulated pass through an output register slice.
module accumulate_output_buffer
  import acc_buffer_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int ACC_WIDTH   = 24,
  parameter int IN_NUM      = 8,
  parameter int BUFFER_SIZE = 512,
  parameter int REPEAT      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in [IN_NUM],
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  output logic [ACC_WIDTH-1:0]  data_out [IN_NUM],
  output logic                  data_out_valid,
  input  logic                  data_out_ready
);

  localparam int AW = $clog2(BUFFER_SIZE);
  localparam int PW = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam logic [AW-1:0] BEAT_MAX = AW'(BUFFER_SIZE - 1);
  localparam logic [PW-1:0] PASS_MAX = PW'(REPEAT - 1);

  logic [AW-1:0]         beat_cnt;
  logic [PW-1:0]         pass_cnt;
  acc_phase_t            phase;
  logic                  last_pass;
  logic                  accept;

  logic                  s1_valid;
  logic                  s1_last;
  logic                  s1_retire;
  acc_phase_t            s1_phase;
  logic [AW-1:0]         s1_addr;
  logic [DATA_WIDTH-1:0] s1_data [IN_NUM];

  logic [ACC_WIDTH-1:0]  rd_data [IN_NUM];
  logic [ACC_WIDTH-1:0]  sum [IN_NUM];
  logic                  ram_rd;
  logic                  ram_wr;
  logic                  slice_ready;

  assign accept    = data_in_valid && data_in_ready;
  assign last_pass = (pass_cnt == PASS_MAX);

  // With REPEAT==1 the phase reads FIRST while last_pass is also set.
  always_comb begin
    // NOTE: assign a default before any branch so combinational outputs never
    // infer a latch on an uncovered path.
    phase = PH_MIDDLE;
    if (pass_cnt == '0) phase = PH_FIRST;
    else if (last_pass) phase = PH_LAST;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
      pass_cnt <= '0;
    end else if (accept) begin
      if (beat_cnt == BEAT_MAX) begin
        beat_cnt <= '0;
        pass_cnt <= last_pass ? '0 : pass_cnt + PW'(1);
      end else begin
        beat_cnt <= beat_cnt + AW'(1);
      end
    end
  end

  // Only a LAST-pass beat can stall, and only when the output slice is full.
  assign s1_retire     = s1_valid && (!s1_last || slice_ready);
  assign data_in_ready = !s1_valid || s1_retire;

  always_ff @(posedge clk) begin
    if (rst) s1_valid <= 1'b0;
    else if (accept) s1_valid <= 1'b1;
    else if (s1_retire) s1_valid <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_data  <= data_in;
      s1_addr  <= beat_cnt;
      s1_phase <= phase;
      s1_last  <= last_pass;
    end
  end

  // Read data stays put during a LAST stall because reads fire only on accept.
  assign ram_rd = accept && (phase != PH_FIRST);
  assign ram_wr = s1_valid && !s1_last;

  for (genvar g = 0; g < IN_NUM; g++) begin : g_lane
    assign sum[g] = ACC_WIDTH'(sext_lane(SEXT_W'(s1_data[g]), DATA_WIDTH))
                  + ((s1_phase == PH_FIRST) ? '0 : rd_data[g]);

    sdp_ram #(
      .WIDTH(ACC_WIDTH),
      .DEPTH(BUFFER_SIZE)
    ) u_ram (
      .clk    (clk),
      .wr_en  (ram_wr),
      .wr_addr(s1_addr),
      .wr_data(sum[g]),
      .rd_en  (ram_rd),
      .rd_addr(beat_cnt),
      .rd_data(rd_data[g])
    );
  end

  unpacked_register_slice #(
    .DATA_WIDTH(ACC_WIDTH),
    .IN_SIZE   (IN_NUM)
  ) u_out_slice (
    .clk           (clk),
    .rst           (rst),
    .data_in       (sum),
    .data_in_valid (s1_valid && s1_last),
    .data_in_ready (slice_ready),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready)
  );

endmodule

// File: tb/tb_accumulate_output_buffer.sv
// Scoreboard bench: DUT a (24-bit acc) and DUT b (16-bit acc) share REPEAT=4 stimulus,
// DUT c runs REPEAT=1; per-DUT monitors pop expected beats on each output handshake.
module tb_accumulate_output_buffer;

  localparam int N = 2;

  typedef logic [N-1:0][23:0] exp24_t;
  typedef logic [N-1:0][15:0] exp16_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] din_a [N];
  logic        vin_a, rdy_a, rdy_b, vout_a, vout_b, ordy;
  logic [23:0] dout_a [N];
  logic [15:0] dout_b [N];
  logic [15:0] din_c [N];
  logic        vin_c, rdy_c, vout_c, ordy_c;
  logic [23:0] dout_c [N];

  accumulate_output_buffer #(.DATA_WIDTH(16), .ACC_WIDTH(24), .IN_NUM(N), .BUFFER_SIZE(8), .REPEAT(4)) dut_a (
    .clk(clk), .rst(rst), .data_in(din_a), .data_in_valid(vin_a), .data_in_ready(rdy_a),
    .data_out(dout_a), .data_out_valid(vout_a), .data_out_ready(ordy));

  accumulate_output_buffer #(.DATA_WIDTH(16), .ACC_WIDTH(16), .IN_NUM(N), .BUFFER_SIZE(8), .REPEAT(4)) dut_b (
    .clk(clk), .rst(rst), .data_in(din_a), .data_in_valid(vin_a), .data_in_ready(rdy_b),
    .data_out(dout_b), .data_out_valid(vout_b), .data_out_ready(ordy));

  accumulate_output_buffer #(.DATA_WIDTH(16), .ACC_WIDTH(24), .IN_NUM(N), .BUFFER_SIZE(8), .REPEAT(1)) dut_c (
    .clk(clk), .rst(rst), .data_in(din_c), .data_in_valid(vin_c), .data_in_ready(rdy_c),
    .data_out(dout_c), .data_out_valid(vout_c), .data_out_ready(ordy_c));

  exp24_t qa[$];
  exp16_t qb[$];
  exp24_t qc[$];
  int     acc_q[$];
  int     n_checks = 0;
  int     n_fail = 0;
  int     acc_cyc_a, acc_cyc_c, lat_acc_a, lat_acc_c;
  int     first_valid_a = -1;
  int     first_valid_c = -1;
  bit     rand_rdy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  always @(posedge clk) begin
    #1;
    ordy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitors compare the head of each queue every cycle the output is valid, so a
  // stalled beat is checked repeatedly against the same expected value.
  always @(negedge clk) begin
    if (!rst && vout_a) begin
      if (first_valid_a < 0) first_valid_a = cyc;
      if (qa.size() == 0) check("a_extra_beat", 64'(qa.size()), 64'd1);
      else begin
        for (int l = 0; l < N; l++) check($sformatf("a_lane%0d", l), 64'(dout_a[l]), 64'(qa[0][l]));
        if (ordy) void'(qa.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && vout_b) begin
      if (qb.size() == 0) check("b_extra_beat", 64'(qb.size()), 64'd1);
      else begin
        for (int l = 0; l < N; l++) check($sformatf("b_lane%0d", l), 64'(dout_b[l]), 64'(qb[0][l]));
        if (ordy) void'(qb.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && vout_c) begin
      if (first_valid_c < 0) first_valid_c = cyc;
      if (qc.size() == 0) check("c_extra_beat", 64'(qc.size()), 64'd1);
      else begin
        for (int l = 0; l < N; l++) check($sformatf("c_lane%0d", l), 64'(dout_c[l]), 64'(qc[0][l]));
        if (ordy_c) void'(qc.pop_front());
      end
    end
  end

  // Hand-derived LAST-pass results per stimulus mode; mode 3 uses the bench model.
  function automatic void push_expected(input int mode, input int b, input logic [23:0] model [N]);
    exp24_t ea;
    exp16_t eb;
    for (int l = 0; l < N; l++) begin
      case (mode)
        0:       ea[l] = 24'd4;
        1:       ea[l] = 24'(96 + 4 * b + 128 * l);
        2:       ea[l] = 24'hFFFFFC;
        4:       ea[l] = 24'd8;
        6:       ea[l] = (l == 0) ? 24'h01FFFC : 24'hFE0000;
        default: ea[l] = model[l];
      endcase
      eb[l] = (mode == 6) ? ((l == 0) ? 16'hFFFC : 16'h0000) : ea[l][15:0];
    end
    qa.push_back(ea);
    qb.push_back(eb);
  endfunction

  task automatic send_a(input logic [15:0] l0, input logic [15:0] l1, input bit gaps);
    bit got = 1'b0;
    int g;
    din_a[0] = l0;
    din_a[1] = l1;
    vin_a = 1'b1;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      got = rdy_a && rdy_b;
      if (got) begin
        acc_cyc_a = cyc;
        acc_q.push_back(cyc);
      end
      @(posedge clk); #1;
    end
    if (!got) check("a_in_timeout", 64'd0, 64'd1);
    if (gaps) begin
      g = $urandom_range(0, 2);
      if (g > 0) begin
        vin_a = 1'b0;
        repeat (g) begin @(posedge clk); #1; end
      end
    end
  endtask

  task automatic run_tile_a(input int mode, input bit gaps, input int stop_at);
    logic [23:0] model [8][N];
    logic [15:0] v [N];
    for (int b = 0; b < 8; b++) for (int l = 0; l < N; l++) model[b][l] = '0;
    for (int p = 0; p < 4; p++) begin
      for (int b = 0; b < 8; b++) begin
        if (p * 8 + b == stop_at) begin
          vin_a = 1'b0;
          return;
        end
        for (int l = 0; l < N; l++) begin
          case (mode)
            0:       v[l] = 16'd1;
            1:       v[l] = 16'(p * 16 + b + l * 32);
            2:       v[l] = 16'hFFFF;
            3:       v[l] = 16'($urandom);
            4:       v[l] = 16'd2;
            5:       v[l] = 16'h1234;
            default: v[l] = (l == 0) ? 16'h7FFF : 16'h8000;
          endcase
          model[b][l] = model[b][l] + {{8{v[l][15]}}, v[l]};
        end
        if (p == 3) push_expected(mode, b, model[b]);
        send_a(v[0], v[1], gaps);
        if (p == 3 && b == 0) lat_acc_a = acc_cyc_a;
      end
    end
    vin_a = 1'b0;
  endtask

  task automatic send_c(input logic [15:0] l0, input logic [15:0] l1);
    bit got = 1'b0;
    din_c[0] = l0;
    din_c[1] = l1;
    vin_c = 1'b1;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      got = rdy_c;
      if (got) acc_cyc_c = cyc;
      @(posedge clk); #1;
    end
    if (!got) check("c_in_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 400 && (qa.size() > 0 || qb.size() > 0 || qc.size() > 0); n++) begin
      @(posedge clk); #1;
    end
    check({tag, "_a_left"}, 64'(qa.size()), 64'd0);
    check({tag, "_b_left"}, 64'(qb.size()), 64'd0);
    check({tag, "_c_left"}, 64'(qc.size()), 64'd0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_a_valid"}, 64'(vout_a), 64'd0);
    check({tag, "_a_data0"}, 64'(dout_a[0]), 64'd0);
    check({tag, "_a_ready"}, 64'(rdy_a), 64'd1);
    check({tag, "_c_valid"}, 64'(vout_c), 64'd0);
    check({tag, "_c_ready"}, 64'(rdy_c), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] c_vals [8];
    exp24_t ec;
    c_vals = '{16'h0000, 16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000, 16'hFFFB, 16'h1234, 16'hC000};
    vin_a = 1'b0; vin_c = 1'b0; ordy = 1'b1; ordy_c = 1'b1;
    din_a = '{default: '0};
    din_c = '{default: '0};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_state("reset");

    // All ones over four passes; first output two cycles after the first LAST accept.
    run_tile_a(0, 1'b0, -1);
    drain("ones");
    check("a_latency", 64'(first_valid_a - lat_acc_a), 64'd2);

    run_tile_a(1, 1'b0, -1);
    drain("ramp");

    run_tile_a(2, 1'b0, -1);
    run_tile_a(6, 1'b0, -1);
    drain("wrap");

    rand_rdy = 1'b1;
    run_tile_a(3, 1'b1, -1);
    run_tile_a(3, 1'b1, -1);
    drain("random");
    rand_rdy = 1'b0;
    @(posedge clk); #1;

    // Abort at pass 2 beat 3; the next tile must ignore the stale RAM contents.
    run_tile_a(5, 1'b0, 19);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_state("midreset");
    run_tile_a(4, 1'b0, -1);
    drain("after_reset");

    acc_q.delete();
    run_tile_a(0, 1'b0, -1);
    run_tile_a(4, 1'b0, -1);
    drain("b2b");
    check("b2b_accepts", 64'(acc_q.size()), 64'd64);
    if (acc_q.size() == 64) check("b2b_span", 64'(acc_q[63] - acc_q[0]), 64'd63);

    // REPEAT==1 passes each beat straight through, sign-extended.
    for (int b = 0; b < 8; b++) begin
      ec[0] = {{8{c_vals[b][15]}}, c_vals[b]};
      ec[1] = {{8{~c_vals[b][15]}}, ~c_vals[b]};
      qc.push_back(ec);
      send_c(c_vals[b], ~c_vals[b]);
      if (b == 0) lat_acc_c = acc_cyc_c;
    end
    vin_c = 1'b0;
    drain("repeat1");
    check("c_latency", 64'(first_valid_c - lat_acc_c), 64'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
